// File: rtl/descrambler15.sv
// Receive-side descrambler: strips a programmable Galois LFSR keystream from 32-bit
// words, keeps one keystream-selected byte lane, and queues bytes in a small FIFO.
module descrambler15 #(
  parameter logic [11:0] ADDR_SEED  = 12'h0F0,
  parameter logic [11:0] ADDR_TAPS  = 12'h0F1,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_write,
  input  logic [11:0] i_addr,
  input  logic [31:0] i_lfsrdin,
  input  logic        i_pushin,
  input  logic [31:0] i_datain,
  output logic        o_stopout,
  input  logic        i_stopin,
  output logic        o_pushout,
  output logic [7:0]  o_dataout
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   r_seed;
  logic [31:0]   r_taps;
  logic [31:0]   r_state;
  logic          r_s1Valid;
  logic [7:0]    r_s1Byte;
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          r_stopout;

  logic          w_accept;
  logic          w_seedWr;
  logic          w_tapsWr;
  logic [31:0]   w_seedVal;
  logic [31:0]   w_word;
  logic [1:0]    w_lane;
  logic [7:0]    w_byte;
  logic [31:0]   w_nextState;
  logic          w_fifoPush;
  logic          w_fifoPop;
  logic [CW-1:0] w_countNext;
  logic [CW-1:0] w_occNext;

  assign w_accept    = i_pushin && !r_stopout;
  assign w_seedWr    = i_write && (i_addr == ADDR_SEED);
  assign w_tapsWr    = i_write && (i_addr == ADDR_TAPS);
  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  assign w_seedVal   = (i_lfsrdin == 32'h0) ? 32'h0000_0001 : i_lfsrdin;
  assign w_word      = i_datain ^ r_state;
  assign w_lane      = r_state[31:30];
  assign w_byte      = w_word[8*w_lane +: 8];
  assign w_nextState = (r_state >> 1) ^ (r_state[0] ? r_taps : 32'h0);

  assign w_fifoPush  = r_s1Valid;
  assign w_fifoPop   = (r_count != '0) && !i_stopin;
  assign w_countNext = r_count + CW'(w_fifoPush) - CW'(w_fifoPop);
  assign w_occNext   = w_countNext + CW'(w_accept);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_seed  <= 32'h0000_0001;
      r_taps  <= 32'h8020_0003;
      r_state <= 32'h0000_0001;
    end else begin
      if (w_seedWr) begin
        r_seed  <= w_seedVal;
        r_state <= w_seedVal;
      end else if (w_accept) begin
        r_state <= w_nextState;
      end
      if (w_tapsWr) begin
        r_taps <= i_lfsrdin;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1Valid <= 1'b0;
      r_s1Byte  <= 8'h00;
    end else begin
      r_s1Valid <= w_accept;
      if (w_accept) begin
        r_s1Byte <= w_byte;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_fifoPush && !i_rst) begin
      r_fifo[r_wrPtr] <= r_s1Byte;
    end
  end

  // stopout looks one cycle ahead so a word accepted now always has a free slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
      r_stopout <= 1'b0;
    end else begin
      assert (!(w_fifoPush && !w_fifoPop && (r_count == CW'(FIFO_DEPTH))));
      assert (r_count <= CW'(FIFO_DEPTH));
      assert (r_seed != 32'h0);
      if (w_fifoPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_fifoPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      r_count   <= w_countNext;
      r_stopout <= (w_occNext >= CW'(3));
    end
  end

  assign o_stopout = r_stopout;
  assign o_pushout = (r_count != '0);
  assign o_dataout = (r_count != '0) ? r_fifo[r_rdPtr] : 8'h00;

endmodule

// File: doc/descrambler15.md
# descrambler15

Receive-side counterpart of the scrambler datapath. Accepts 32-bit scrambled words and strips the keystream with a programmable 32-bit Galois LFSR. It extracts the one data byte per word from a keystream-selected byte lane, discards the entropy filler, and delivers bytes through a 4-entry output FIFO with stop-based backpressure. Sits at the receiver input; configured over the same write/addr/lfsrdin bus as the scrambler LFSR bank.

## Interface
- ADDR_SEED, 12'h0F0, config address of the seed register
- ADDR_TAPS, 12'h0F1, config address of the tap (polynomial) register
- FIFO_DEPTH, 4, output FIFO entries (fixed at 4 for this revision)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- write  in  1  config write strobe
- addr  in  12  config address
- lfsrdin  in  32  config write data
- pushin  in  1  scrambled word valid
- datain  in  32  scrambled word
- stopout  out  1  source must not push while high
- stopin  in  1  sink backpressure; FIFO does not pop while high
- pushout  out  1  dataout valid
- dataout  out  8  descrambled data byte

## Operation
- Registers: seed SD (reset 32'h0000_0001), taps T (reset 32'h8020_0003), LFSR state S (reset 32'h0000_0001).
- Config: write && addr==ADDR_SEED -> SD <= lfsrdin and S <= lfsrdin; a zero value is replaced by 32'h0000_0001 in both. write && addr==ADDR_TAPS -> T <= lfsrdin. Other addresses ignored.
- Accept: word accepted when pushin && !stopout. pushin while stopout is high is ignored (no state change).
- Per accepted word, using current S:
  - W = datain ^ S
  - lane = S[31:30]
  - byte = W[8*lane +: 8]
  - S advances once: S <= (S >> 1) ^ (S[0] ? T : 32'h0).
- Same-cycle seed write and accept: word uses pre-write S; S after the cycle = written seed (no advance applied). Taps write with accept: advance uses old T.
- Pipeline: stage 1 register (byte, valid) loaded on accept; stage 1 writes into the FIFO the following cycle.
- FIFO: pops when pushout && !stopin. Simultaneous write and pop is allowed at any fill level, including full.
- Occupancy = FIFO count + stage-1 valid. stopout is registered: high for the next cycle iff occupancy after the current cycle's updates is >= 3. This guarantees occupancy never exceeds 4 and no byte is ever dropped.
- pushout = FIFO non-empty; dataout = FIFO head (8'h00 when empty).

## Timing
- Reset values: pushout=0, dataout=8'h00, stopout=0; FIFO empty, stage 1 invalid, SD/T/S as above. Reset wins over write and pushin in the same cycle.
- Reset mid-stream flushes stage 1 and the FIFO; bytes in flight are lost; S returns to 32'h1 (not SD).
- Latency: word accepted at edge N -> byte in stage 1 after N -> in FIFO after N+1. pushout high in cycle N+2 when the FIFO was empty.
- Throughput: one word per cycle while stopin=0; sustained streaming keeps occupancy <= 2, so stopout stays low.
- FIFO pointers wrap modulo 4; count saturates neither way (overflow/underflow are unreachable by construction; an assertion checks this).
- dataout holds stable while pushout && stopin.

## Test plan
- Reset: assert rst 2 cycles with pushin=1, write=1 -> pushout=0, dataout=8'h00, stopout=0, S=32'h1 afterwards.
- Default keystream: after reset push 32'h0000_00A4 then 32'h1234_5678, stopin=0 -> bytes 8'hA5 (lane 0) then 8'h14 (S=32'h8020_0003, lane 2, W=32'h9214_567B), first pushout 2 cycles after first accept.
- Seed load: write addr 12'h0F0, lfsrdin 32'hC000_0000; push 32'h0000_0000 -> lane 3, byte 8'hC0. Repeat with lfsrdin 0 -> behaves as seed 32'h1.
- Same-cycle write+push: S=32'h1, write seed 32'h4000_0000 with push 32'h0 -> byte 8'h01; next push 32'h0 -> lane 1, byte 8'h00, S then advances from 32'h4000_0000.
- Backpressure: stopin=1, push 3 consecutive words -> stopout high; a 4th pushin is ignored (S unchanged). Release stopin -> 3 bytes out in order, stopout drops once occupancy < 3.
- Random stream vs. software model of scrambler keystream with stopin toggling randomly -> byte-exact match, no loss, no duplicates.
